data_ram_wbuf: RTL and testbench

DATA_RAM_WBUF -- requirements
Module: data_ram_wbuf

---
 rtl/data_ram_wbuf_pkg.sv | 25 ++
 rtl/data_ram_wbuf_fifo.sv | 81 ++++++++
 rtl/data_ram_wbuf.sv | 83 ++++++++
 tb/tb_data_ram_wbuf.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_wbuf_pkg.sv
// Shared widths and constants for the data RAM with write buffer.
// Also holds the byte-lane merge helper used by the FIFO and the RAM.
package data_ram_wbuf_pkg;

  localparam int REG_BUS_W = 32;
  localparam int SEL_W = REG_BUS_W / 8;
  localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;
  localparam int WB_DEPTH_DEF = 4;

  function automatic logic [REG_BUS_W-1:0] lane_merge(
    input logic [REG_BUS_W-1:0] base,
    input logic [REG_BUS_W-1:0] data,
    input logic [SEL_W-1:0]     sel
  );
    logic [REG_BUS_W-1:0] r;
    r = base;
    for (int b = 0; b < SEL_W; b++) begin
      if (sel[b]) begin
        r[8*b +: 8] = data[8*b +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/data_ram_wbuf_fifo.sv
// Write-buffer FIFO of {word index, sel, data} entries.
// Provides a per-lane forwarding lookup, youngest matching entry wins.
module wbuf_fifo
  import data_ram_wbuf_pkg::*;
#(
  parameter int IDX_W = 10,
  parameter int DEPTH = WB_DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [IDX_W-1:0]     push_idx,
  input  logic [SEL_W-1:0]     push_sel,
  input  logic [REG_BUS_W-1:0] push_data,
  output logic [IDX_W-1:0]     head_idx,
  output logic [SEL_W-1:0]     head_sel,
  output logic [REG_BUS_W-1:0] head_data,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty,
  input  logic [IDX_W-1:0]     look_idx,
  input  logic [REG_BUS_W-1:0] look_base,
  output logic [REG_BUS_W-1:0] look_data
);

  logic [IDX_W-1:0]     e_idx  [DEPTH];
  logic [SEL_W-1:0]     e_sel  [DEPTH];
  logic [REG_BUS_W-1:0] e_data [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] slot;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  assign head_idx  = e_idx[head];
  assign head_sel  = e_sel[head];
  assign head_data = e_data[head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push && !full) begin
        tail  <= tail + 1'b1;
        count <= count + 1'b1;
      end else if (pop && !empty) begin
        head  <= head + 1'b1;
        count <= count - 1'b1;
      end
    end
  end

  // Entry storage needs no reset; only occupancy decides validity.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      e_idx[tail]  <= push_idx;
      e_sel[tail]  <= push_sel;
      e_data[tail] <= push_data;
    end
  end

  // Walk oldest to youngest so later entries override earlier lanes.
  always_comb begin
    look_data = look_base;
    slot      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head + PTR_W'(k);
      if (CNT_W'(k) < count && e_idx[slot] == look_idx) begin
        look_data = lane_merge(look_data, e_data[slot], e_sel[slot]);
      end
    end
  end

endmodule

// File: rtl/data_ram_wbuf.sv
// Data RAM with posted-write buffer and zero-latency read forwarding.
// Buffer drains one entry per idle or stalled cycle.
module data_ram_wbuf
  import data_ram_wbuf_pkg::*;
#(
  parameter int DEPTH_W  = 10,
  parameter int WB_DEPTH = WB_DEPTH_DEF,
  localparam int CNT_W   = $clog2(WB_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce_i,
  input  logic                 we_i,
  input  logic [31:0]          addr_i,
  input  logic [SEL_W-1:0]     sel_i,
  input  logic [REG_BUS_W-1:0] data_i,
  output logic [REG_BUS_W-1:0] data_o,
  output logic                 stall_req_o,
  output logic [CNT_W-1:0]     wb_count_o
);

  localparam int WORDS = 1 << DEPTH_W;

  logic [REG_BUS_W-1:0] mem [WORDS];

  logic [DEPTH_W-1:0]   idx;
  logic                 wr_req;
  logic                 rd_req;
  logic                 push;
  logic                 drain;
  logic                 full;
  logic                 empty;
  logic [DEPTH_W-1:0]   head_idx;
  logic [SEL_W-1:0]     head_sel;
  logic [REG_BUS_W-1:0] head_data;
  logic [REG_BUS_W-1:0] fwd_data;
  logic                 unused_addr;

  assign idx         = addr_i[DEPTH_W+1:2];
  assign unused_addr = ^{addr_i[31:DEPTH_W+2], addr_i[1:0]};

  assign wr_req      = ce_i && we_i;
  assign rd_req      = ce_i && !we_i;
  assign stall_req_o = wr_req && full;
  assign push        = wr_req && !full;
  assign drain       = !empty && (!ce_i || stall_req_o);

  wbuf_fifo #(
    .IDX_W (DEPTH_W),
    .DEPTH (WB_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (push),
    .pop       (drain),
    .push_idx  (idx),
    .push_sel  (sel_i),
    .push_data (data_i),
    .head_idx  (head_idx),
    .head_sel  (head_sel),
    .head_data (head_data),
    .count     (wb_count_o),
    .full      (full),
    .empty     (empty),
    .look_idx  (idx),
    .look_base (mem[idx]),
    .look_data (fwd_data)
  );

  // Array is deliberately not reset; only the buffer is cleared.
  always_ff @(posedge clk) begin
    if (drain) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (head_sel[b]) begin
          mem[head_idx][8*b +: 8] <= head_data[8*b +: 8];
        end
      end
    end
  end

  assign data_o = rd_req ? fwd_data : ZERO_WORD;

endmodule

// File: tb/tb_data_ram_wbuf.sv
// Directed bench for data_ram_wbuf with a queue-based reference model.
// Model tracks which array bytes are known so uninitialised RAM is not compared.
module tb_data_ram_wbuf;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [3:0]  sel_i = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        stall_req_o;
  logic [2:0]  wb_count_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [9:0]  idx;
    logic [3:0]  sel;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  logic [7:0] mb [4096];
  bit         kb [4096];

  data_ram_wbuf dut (
    .clk         (clk),
    .rst         (rst),
    .ce_i        (ce_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .sel_i       (sel_i),
    .data_i      (data_i),
    .data_o      (data_o),
    .stall_req_o (stall_req_o),
    .wb_count_o  (wb_count_o)
  );

  always #5 clk = ~clk;

  function automatic void model_read(
    input  logic [31:0] a,
    output logic [31:0] d,
    output logic [31:0] m
  );
    int w;
    w = int'(a[11:2]);
    d = '0;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      d[8*b +: 8] = mb[w*4+b];
      m[8*b +: 8] = kb[w*4+b] ? 8'hff : 8'h00;
      foreach (q[i]) begin
        if (q[i].idx == a[11:2] && q[i].sel[b]) begin
          d[8*b +: 8] = q[i].data[8*b +: 8];
          m[8*b +: 8] = 8'hff;
        end
      end
    end
  endfunction

  // Reference: accepted writes queue up, idle/stalled cycles retire the oldest.
  always @(posedge clk) begin
    if (rst) begin
      if (ce_i && we_i && q.size() < 4) begin
        q.push_back('{addr_i[11:2], sel_i, data_i});
      end else if (q.size() > 0 && (!ce_i || we_i)) begin
        ent_t e;
        e = q.pop_front();
        for (int b = 0; b < 4; b++) begin
          if (e.sel[b]) begin
            mb[int'(e.idx)*4+b] = e.data[8*b +: 8];
            kb[int'(e.idx)*4+b] = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge rst) q.delete();

  always @(negedge clk) begin
    logic        es;
    logic [31:0] ed;
    logic [31:0] em;
    es = ce_i && we_i && (q.size() == 4);
    checks++;
    if (stall_req_o !== es) begin
      errors++;
      $display("FAIL cmp_stall t=%0t got=%b want=%b", $time, stall_req_o, es);
    end
    checks++;
    if (wb_count_o !== 3'(q.size())) begin
      errors++;
      $display("FAIL cmp_count t=%0t got=%0d want=%0d", $time, wb_count_o, q.size());
    end
    if (ce_i && !we_i) begin
      model_read(addr_i, ed, em);
    end else begin
      ed = '0;
      em = '1;
    end
    checks++;
    if (((data_o ^ ed) & em) !== 32'h0) begin
      errors++;
      $display("FAIL cmp_data t=%0t got=%h want=%h mask=%h", $time, data_o, ed, em);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic drive(
    input logic c, input logic w, input logic [31:0] a,
    input logic [3:0] s, input logic [31:0] d
  );
    @(posedge clk);
    #1;
    ce_i = c; we_i = w; addr_i = a; sel_i = s; data_i = d;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_count", 32'(wb_count_o), 32'd0);
    chk("rst_stall", 32'(stall_req_o), 32'd0);
    chk("rst_data", data_o, 32'h0);
    #1 rst = 1'b1;

    drive(1, 1, 32'h40, 4'hf, 32'h11223344);
    drive(1, 0, 32'h40, 4'h0, 32'h0);
    chk("fwd_40", data_o, 32'h11223344);
    chk("fwd_40_cnt", 32'(wb_count_o), 32'd1);
    idle();
    idle();

    drive(1, 1, 32'h80, 4'hf, 32'hAABBCCDD);
    drive(1, 1, 32'h80, 4'h1, 32'h000000EE);
    drive(1, 0, 32'h80, 4'h0, 32'h0);
    chk("merge_80", data_o, 32'hAABBCCEE);
    chk("merge_80_cnt", 32'(wb_count_o), 32'd2);
    idle();
    idle();
    drive(1, 0, 32'h80, 4'h0, 32'h0);
    chk("array_80", data_o, 32'hAABBCCEE);
    chk("array_80_cnt", 32'(wb_count_o), 32'd0);

    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 32'(i*4), 4'hf, 32'h1000_0000 + 32'(i));
      chk("b2b_nostall", 32'(stall_req_o), 32'd0);
    end
    drive(1, 1, 32'h10, 4'hf, 32'h1000_0004);
    chk("b2b_stall", 32'(stall_req_o), 32'd1);
    chk("b2b_stall_cnt", 32'(wb_count_o), 32'd4);
    drive(1, 1, 32'h10, 4'hf, 32'h1000_0004);
    chk("b2b_accept", 32'(stall_req_o), 32'd0);
    chk("b2b_accept_cnt", 32'(wb_count_o), 32'd3);
    idle();
    chk("b2b_full_again", 32'(wb_count_o), 32'd4);
    repeat (4) idle();
    drive(1, 0, 32'h10, 4'h0, 32'h0);
    chk("b2b_rd10", data_o, 32'h1000_0004);
    chk("b2b_empty", 32'(wb_count_o), 32'd0);

    drive(1, 1, 32'h20, 4'hf, 32'h2020_2020);
    drive(1, 1, 32'h24, 4'hf, 32'h2424_2424);
    drive(1, 1, 32'h28, 4'hc, 32'h2828_0000);
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 32'h20 + 32'((i % 3) * 4), 4'h0, 32'h0);
    end
    chk("rd_nodrain_cnt", 32'(wb_count_o), 32'd3);
    idle();
    drive(1, 0, 32'h24, 4'h0, 32'h0);
    chk("idle_drain_cnt", 32'(wb_count_o), 32'd2);
    chk("rd_24", data_o, 32'h2424_2424);
    repeat (3) idle();

    drive(1, 1, 32'h1004, 4'hf, 32'h5A5A_0F0F);
    drive(1, 0, 32'h4, 4'h0, 32'h0);
    chk("alias_fwd", data_o, 32'h5A5A_0F0F);
    idle();
    idle();
    drive(1, 0, 32'h4, 4'h0, 32'h0);
    chk("alias_array", data_o, 32'h5A5A_0F0F);

    drive(1, 1, 32'h100, 4'hf, 32'hDEADBEEF);
    idle();
    idle();
    drive(1, 1, 32'h100, 4'hf, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    ce_i = 0; we_i = 0; addr_i = '0; data_i = '0; sel_i = '0;
    chk("pre_rst_cnt", 32'(wb_count_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_cnt", 32'(wb_count_o), 32'd0);
    chk("async_rst_stall", 32'(stall_req_o), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    drive(1, 0, 32'h100, 4'h0, 32'h0);
    chk("rst_discard", data_o, 32'hDEADBEEF);
    chk("rst_discard_cnt", 32'(wb_count_o), 32'd0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
